data_ram_arbiter: RTL and testbench

//   Shares the single data blockram between the brainfuck proc core and a host/debug

---
 rtl/data_ram_arbiter.sv | 115 +++++++++++
 tb/tb_data_ram_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Shares the data blockram between the proc core and a host/debug port.
// Round-robin arbitration with host lock; define ARB_HOST_PRIORITY_EN for strict host priority.
module data_ram_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {OwnCpu, OwnHost} owner_e;

  owner_e last_owner_q, last_owner_d;
  logic   locked_q, locked_d;
  logic   rd_cpu_q, rd_cpu_d;
  logic   rd_host_q, rd_host_d;
  logic   host_win;

  // Grants are gated by reset_n so they drop the moment reset asserts.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
`ifdef ARB_HOST_PRIORITY_EN
    host_win = 1'b1;
`else
    host_win = (last_owner_q == OwnCpu);
`endif
    if (reset_n) begin
      if (locked_q) begin
        host_gnt = host_req;
      end else if (host_req && cpu_req) begin
        host_gnt = host_win;
        cpu_gnt  = !host_win;
      end else begin
        host_gnt = host_req;
        cpu_gnt  = cpu_req;
      end
    end
  end

  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_wen   = cpu_we;
      mem_ren   = !cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_wen   = host_we;
      mem_ren   = !host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (host_gnt) begin
      last_owner_d = OwnHost;
    end else if (cpu_gnt) begin
      last_owner_d = OwnCpu;
    end
    locked_d = locked_q;
    if (!host_lock) begin
      locked_d = 1'b0;
    end else if (host_gnt) begin
      locked_d = 1'b1;
    end
    rd_cpu_d  = cpu_gnt && !cpu_we;
    rd_host_d = host_gnt && !host_we;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner_q <= OwnCpu;
      locked_q     <= 1'b0;
      rd_cpu_q     <= 1'b0;
      rd_host_q    <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      locked_q     <= locked_d;
      rd_cpu_q     <= rd_cpu_d;
      rd_host_q    <= rd_host_d;
    end
  end

  assign cpu_rvalid  = rd_cpu_q;
  assign host_rvalid = rd_host_q;
  assign cpu_rdata   = rd_cpu_q ? mem_rdata : '0;
  assign host_rdata  = rd_host_q ? mem_rdata : '0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomized self-checking bench for data_ram_arbiter against a cycle-level arbitration model.
// Honours ARB_HOST_PRIORITY_EN in the model when the design is built with it.
module tb_data_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       mem_wen, mem_ren;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Blockram environment: one-cycle read latency, write visible on the next cycle.
  bit [7:0] ram [256];

  // Reference model state.
  bit       m_last_host;
  bit       m_locked;
  bit       m_rv_cpu, m_rv_host;
  bit [7:0] m_rdata;
  bit [7:0] shadow [256];

  data_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_lock  (host_lock),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_host = 1'b0;
    m_locked    = 1'b0;
    m_rv_cpu    = 1'b0;
    m_rv_host   = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check combinational and registered outputs, advance model.
  task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                      input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                      input logic hl);
    bit       eh, ec;
    bit [7:0] ea, ed;
    @(negedge clk);
    cpu_req = cr;  cpu_we = cw;  cpu_addr = ca;  cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
    #1;
    if (m_locked) begin
      eh = hr; ec = 1'b0;
    end else if (hr && cr) begin
`ifdef ARB_HOST_PRIORITY_EN
      eh = 1'b1;
`else
      eh = !m_last_host;
`endif
      ec = !eh;
    end else begin
      eh = hr; ec = cr;
    end
    ea = ec ? ca : (eh ? ha : 8'h00);
    ed = ec ? cd : (eh ? hd : 8'h00);
    check("cpu_gnt", cpu_gnt, ec);
    check("host_gnt", host_gnt, eh);
    check("mem_wen", mem_wen, (ec && cw) || (eh && hw));
    check("mem_ren", mem_ren, (ec && !cw) || (eh && !hw));
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    check("cpu_rvalid", cpu_rvalid, m_rv_cpu);
    check("host_rvalid", host_rvalid, m_rv_host);
    check("cpu_rdata", cpu_rdata, m_rv_cpu ? m_rdata : 8'h00);
    check("host_rdata", host_rdata, m_rv_host ? m_rdata : 8'h00);
    m_rv_cpu  = ec && !cw;
    m_rv_host = eh && !hw;
    if (ec || eh) begin
      if ((ec && cw) || (eh && hw)) shadow[ea] = ed;
      else m_rdata = shadow[ea];
      m_last_host = eh;
    end
    if (!hl) m_locked = 1'b0;
    else if (eh) m_locked = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Assert reset with requests still active; everything must drop in the same cycle.
  task automatic pulse_reset();
    @(negedge clk);
    cpu_req = 1'b1; host_req = 1'b1; cpu_we = 1'b0; host_we = 1'b1;
    reset_n = 1'b0;
    #1;
    check("rst_cpu_gnt", cpu_gnt, 1'b0);
    check("rst_host_gnt", host_gnt, 1'b0);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_host_rvalid", host_rvalid, 1'b0);
    check("rst_mem_wen", mem_wen, 1'b0);
    check("rst_mem_ren", mem_ren, 1'b0);
    model_reset();
    @(negedge clk);
    cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_lock = 1'b0;
    model_reset();
    #1;
    check("reset_cpu_gnt", cpu_gnt, 1'b0);
    check("reset_host_gnt", host_gnt, 1'b0);
    check("reset_mem_addr", mem_addr, 8'h00);
    check("reset_cpu_rdata", cpu_rdata, 8'h00);
    check("reset_host_rdata", host_rdata, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // CPU only: write then read back.
    step(1'b1, 1'b1, 8'h10, 8'h2A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle();
    check("dir_cpu_rdata_2a", cpu_rdata, 8'h2A);

    // Contention: both read continuously.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'(i), 8'h00, 1'b0);
    end
    idle();

    // Lock: host reads 0..3 with gaps while the CPU keeps requesting.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'(i), 8'h00, 1'b1);
      step(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      check("dir_lock_cpu_blocked", cpu_gnt, 1'b0);
    end
    step(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("dir_unlock_same_cycle", cpu_gnt, 1'b0);
    step(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("dir_unlock_next_cycle", cpu_gnt, 1'b1);
    idle();

    // Host write followed by CPU read of the same address.
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h80, 8'h55, 1'b0);
    step(1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle();
    check("dir_order_rdata_55", cpu_rdata, 8'h55);

    // Both request for 4 cycles (strict priority build: host every time).
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'h30, 8'(i), 1'b1, 1'b0, 8'h31, 8'h00, 1'b0);
    end
    idle();

    pulse_reset();

    // Randomized traffic with occasional lock and reset.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom_range(0, 2) != 0), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom_range(0, 5) == 0));
      end
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
